buffer_reader: RTL and testbench
================================

Name: buffer_reader

Overview:
- Read-side engine for the 4096x8 single-port sample buffer (ports clka/addra/dia/wea/doa, NOREG, 1-cycle read latency).
- After capture completes, it walks the buffer from a trigger-aligned start address, wrapping at the top.
- It streams bytes to the MCU interface over a valid/ready byte handshake with full backpressure support.
- It drives the buffer's address and write-enable ports while it owns the buffer.

Parameters:
- ADDR_WIDTH, 12, buffer address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, sample width.

Ports:
- clka  in  1  system clock; all logic on rising edge.
- rsta  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a readout when idle.
- abort  in  1  one-cycle pulse; cancels an active readout.
- start_addr  in  ADDR_WIDTH  first buffer address to read; sampled with start.
- read_count  in  ADDR_WIDTH+1  bytes to read; 0 means full depth (4096); sampled with start.
- busy  out  1  high from the cycle after start is accepted until completion or abort.
- done  out  1  one-cycle pulse on completion.
- mem_addr  out  ADDR_WIDTH  to buffer addra.
- mem_we  out  1  to buffer wea; constant 0.
- mem_dout  in  DATA_WIDTH  from buffer doa; valid the cycle after mem_addr is registered.
- out_data  out  DATA_WIDTH  streamed byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.

Behaviour:
- Reset (rsta=1 at an edge):
  - State goes to IDLE.
  - busy, done, out_valid, mem_we and mem_addr are 0. out_data is 0.
  - Internal counters and the skid register are cleared.
  - Reset mid-readout discards everything and gives no done pulse.
- States:
  - IDLE: start=1 loads the address pointer with start_addr and the remaining-count with read_count (0 loads 4096). Next state is RUN.
  - RUN: issues one address per cycle while the skid buffer has room. When the issue count is exhausted, next state is DRAIN.
  - DRAIN: waits until every issued byte has been accepted. Then it pulses done and returns to IDLE.
- Pipeline:
  - mem_addr is registered.
  - The byte returned from mem_dout is captured into a 2-entry output skid: an output register plus one spare.
  - Addresses are issued only when, after counting in-flight reads, at most 2 bytes would be outstanding. No byte is ever lost under backpressure.
- Latency: start sampled at edge N gives mem_addr=start_addr after edge N+1, and out_valid=1 with byte[start_addr] after edge N+2.
- Throughput: with out_ready held 1, exactly one byte per cycle, with no bubbles, until the count is exhausted.
- Handshake:
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - out_valid never drops without acceptance, except on abort or reset.
- Wrap-around: the address pointer increments modulo 2**ADDR_WIDTH, so 4095 goes to 0.
- Completion:
  - done=1 for exactly one cycle, the cycle after the final byte is accepted.
  - busy falls on the same edge that done rises.
- Start while busy is ignored. start and abort together in IDLE: abort wins, nothing starts.
- Abort in RUN or DRAIN:
  - Next edge: out_valid=0, skid flushed, state IDLE, busy=0, no done pulse.
  - In-flight read data is discarded.
- mem_we stays 0 in every state. The buffer's write side is muxed away by the capture controller while busy=1.

Optional Feature:
- Macro BUFFER_READER_STRIDE_EN.
- Defined:
  - Adds input port addr_step [3:0], sampled with start.
  - The address pointer advances by addr_step modulo 4096 per issued byte (decimated readout). addr_step=0 is treated as 1.
  - read_count still counts output bytes.
- Undefined:
  - No addr_step port. The step is fixed at 1.

Test Plan:
- Reset then idle: rsta high 2 cycles -> busy=0, out_valid=0, done=0, mem_addr=0, mem_we=0 throughout.
- Basic stream: buffer preloaded mem[i]=i[7:0]; start, start_addr=0x010, read_count=4, out_ready=1 -> out_valid first high 2 cycles after start; bytes 0x10,0x11,0x12,0x13 on consecutive cycles; done pulse 1 cycle after 0x13 accepted.
- Wrap plus full depth:
  - start_addr=0xFFE, read_count=3 -> bytes 0xFE,0xFF,0x00 (addresses 0xFFE,0xFFF,0x000).
  - read_count=0 -> exactly 4096 accepted bytes, then done.
- Backpressure: out_ready toggles 1,0,0,1,0,1… over read_count=16 -> out_data stable while stalled; the accepted sequence is exactly the 16 consecutive bytes with no loss or duplication.
- Abort/restart: abort 5 cycles into a 100-byte read -> next cycle busy=0, out_valid=0, no done. A new start with start_addr=0x200 then streams 0x00,0x01… from 0x200 correctly.
- Stride (BUFFER_READER_STRIDE_EN): start_addr=0xFFC, addr_step=3, read_count=4 -> addresses 0xFFC,0xFFF,0x002,0x005; addr_step=0 behaves as step 1.

Source files
------------

// File: rtl/buffer_reader.sv
// buffer_reader: read-side engine for the capture sample buffer.
// Walks the buffer from a start address (wrapping at the top) and streams
// bytes over a valid/ready handshake through a 2-entry output skid.
// The buffer is a 1-cycle-latency RAM whose read data for the address held
// in mem_addr is captured on the following clock edge.
// Optional feature macro: BUFFER_READER_STRIDE_EN (adds addr_step input for
// decimated readout).
module buffer_reader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   read_count,
`ifdef BUFFER_READER_STRIDE_EN
    input  logic [3:0]            addr_step,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] step;
    logic [CW-1:0]         issue_left;
    logic [CW-1:0]         accept_left;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] spare;
    logic                  pop;
    logic                  issue;
    logic                  accept_start;
    logic [2:0]            pending;
    logic [CW-1:0]         load_count;

    // Handshake, skid-room check and start qualification.
    assign pop          = out_valid & out_ready;
    assign pending      = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue        = (state == RUN) && (issue_left != '0) && (pending <= 3'd1);
    assign accept_start = (state == IDLE) && start && !abort;
    assign load_count   = (read_count == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : read_count;

`ifdef BUFFER_READER_STRIDE_EN
    logic [3:0] step_q;

    // Capture the address stride with start; a zero stride reads contiguously.
    always_ff @(posedge clka) begin
        if (rsta) begin
            step_q <= 4'd1;
        end else if (accept_start) begin
            step_q <= (addr_step == 4'd0) ? 4'd1 : addr_step;
        end
    end

    assign step = ADDR_WIDTH'(step_q);
`else
    assign step = ADDR_WIDTH'(1);
`endif

    // Control FSM, address issue, skid buffer and registered outputs.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            ptr         <= '0;
            issue_left  <= '0;
            accept_left <= '0;
            inflight    <= 1'b0;
            occ         <= 2'd0;
            spare       <= '0;
        end else begin
            done     <= 1'b0;
            mem_we   <= 1'b0;
            inflight <= issue;

            if (issue) begin
                mem_addr   <= ptr;
                ptr        <= ptr + step;
                issue_left <= issue_left - CW'(1);
            end

            // The room check guarantees no capture arrives while both entries are full.
            case (occ)
                2'd0: begin
                    if (inflight) begin
                        out_data  <= mem_dout;
                        out_valid <= 1'b1;
                        occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && !pop) begin
                        spare <= mem_dout;
                        occ   <= 2'd2;
                    end else if (inflight && pop) begin
                        out_data <= mem_dout;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        occ       <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_data <= spare;
                        if (inflight) begin
                            spare <= mem_dout;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase

            if (pop) begin
                accept_left <= accept_left - CW'(1);
            end

            case (state)
                IDLE: begin
                    if (accept_start) begin
                        ptr         <= start_addr;
                        issue_left  <= load_count;
                        accept_left <= load_count;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (issue && (issue_left == CW'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (accept_left == CW'(1))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Abort overrides everything above: flush skid and in-flight read.
            if (abort && (state != IDLE)) begin
                state       <= IDLE;
                busy        <= 1'b0;
                done        <= 1'b0;
                out_valid   <= 1'b0;
                occ         <= 2'd0;
                inflight    <= 1'b0;
                issue_left  <= '0;
                accept_left <= '0;
            end
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader: table-driven readouts plus
// hand-written abort / restart / reset corner sequences, scoreboard checked.
module tb_buffer_reader;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4096;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   read_count = '0;
`ifdef BUFFER_READER_STRIDE_EN
    logic [3:0]    addr_step = 4'd1;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] acc_log[$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_acc_cyc = -10;
    int rdy_mode = 0;

    typedef struct {
        int addr;
        int cnt;
        int step;
        int mode;
        int exp_first;
        int exp_len;
    } vec_t;

    vec_t vecs[$];

    buffer_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .abort     (abort),
        .start_addr(start_addr),
        .read_count(read_count),
`ifdef BUFFER_READER_STRIDE_EN
        .addr_step (addr_step),
`endif
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Buffer model: data for the registered address is presented to the next edge.
    assign mem_dout = mem[mem_addr];

    always #5 clka = ~clka;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer side: scoreboard pop, hold-while-stalled and done timing.
    task automatic monitor();
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] exp;
        forever begin
            @(negedge clka);
            cyc++;
            if (rsta) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk(out_valid == 1'b1, "hold_valid", int'(out_valid), 1);
                    chk(out_data == prev_data, "hold_data", int'(out_data), int'(prev_data));
                end
                if (out_valid && out_ready) begin
                    acc_log.push_back(out_data);
                    last_acc_cyc = cyc;
                    chk(sb.size() != 0, "extra_byte", int'(out_data), -1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        chk(out_data == exp, "data", int'(out_data), int'(exp));
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk(cyc == last_acc_cyc + 1, "done_timing", cyc, last_acc_cyc + 1);
                    chk(sb.size() == 0, "done_early", sb.size(), 0);
                    chk(busy == 1'b0, "busy_fall", int'(busy), 0);
                end
                if (mem_we) chk(mem_we == 1'b0, "mem_we", int'(mem_we), 0);
                prev_stall = out_valid && !out_ready && !abort;
                prev_data  = out_data;
            end
        end
    endtask

    task automatic drive_ready();
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        forever begin
            @(posedge clka);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[k % 6];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    endtask

    task automatic push_expect(input int addr, input int cnt, input int step);
        int n;
        int st;
        n  = (cnt == 0) ? DEPTH : cnt;
        st = (step == 0) ? 1 : step;
        for (int i = 0; i < n; i++) sb.push_back(mem[(addr + i * st) % DEPTH]);
    endtask

    task automatic pulse_start(input int addr, input int cnt, input int step);
        @(posedge clka);
        #1;
        start      = 1'b1;
        start_addr = AW'(addr);
        read_count = (AW + 1)'(cnt);
`ifdef BUFFER_READER_STRIDE_EN
        addr_step  = 4'(step);
`endif
        @(posedge clka);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clka);
        chk(done_cnt == d0 + 1, name, done_cnt - d0, 1);
    endtask

    task automatic run_read(input int addr, input int cnt, input int step, input int mode,
                            input int exp_first, input int exp_len);
        int snap;
        int d0;
        int n;
        rdy_mode = mode;
        n = (cnt == 0) ? DEPTH : cnt;
        push_expect(addr, cnt, step);
        snap = acc_log.size();
        d0 = done_cnt;
        pulse_start(addr, cnt, step);
        @(negedge clka);
        chk(busy == 1'b1, "busy_rise", int'(busy), 1);
        @(negedge clka);
        chk(mem_addr == AW'(addr), "first_addr", int'(mem_addr), addr);
        chk(out_valid == 1'b0, "valid_early", int'(out_valid), 0);
        @(negedge clka);
        chk(out_valid == 1'b1, "first_valid", int'(out_valid), 1);
        wait_done(d0, n * 8 + 100, "done_seen");
        chk(acc_log.size() - snap == exp_len, "byte_count", acc_log.size() - snap, exp_len);
        if (acc_log.size() > snap)
            chk(acc_log[snap] == DW'(exp_first), "first_byte", int'(acc_log[snap]), exp_first);
        repeat (3) @(negedge clka);
        rdy_mode = 0;
    endtask

    task automatic main();
        int d0;
        int snap;
        // Reset held for two edges.
        repeat (2) begin
            @(negedge clka);
            chk(busy == 1'b0, "rst_busy", int'(busy), 0);
            chk(out_valid == 1'b0, "rst_valid", int'(out_valid), 0);
            chk(done == 1'b0, "rst_done", int'(done), 0);
            chk(mem_addr == '0, "rst_addr", int'(mem_addr), 0);
            chk(mem_we == 1'b0, "rst_we", int'(mem_we), 0);
            chk(out_data == '0, "rst_data", int'(out_data), 0);
        end
        @(posedge clka);
        #1;
        rsta = 1'b0;
        repeat (2) @(negedge clka);
        chk(busy == 1'b0, "idle_busy", int'(busy), 0);

        vecs.push_back('{32'h010, 4,  1, 0, 32'h10, 4});
        vecs.push_back('{32'hFFE, 3,  1, 0, 32'hFE, 3});
        vecs.push_back('{32'h123, 16, 1, 1, 32'h23, 16});
        vecs.push_back('{32'h7F0, 40, 1, 2, 32'hF0, 40});
        vecs.push_back('{32'h0FF, 1,  1, 1, 32'hFF, 1});
        vecs.push_back('{32'h000, 0,  1, 0, 32'h00, 4096});
`ifdef BUFFER_READER_STRIDE_EN
        vecs.push_back('{32'hFFC, 4,  3, 0, 32'hFC, 4});
        vecs.push_back('{32'h100, 5,  0, 1, 32'h00, 5});
`endif
        foreach (vecs[i])
            run_read(vecs[i].addr, vecs[i].cnt, vecs[i].step, vecs[i].mode,
                     vecs[i].exp_first, vecs[i].exp_len);

        // Abort five cycles into a 100-byte read, then restart elsewhere.
        push_expect(32'h300, 100, 1);
        d0 = done_cnt;
        pulse_start(32'h300, 100, 1);
        repeat (4) @(posedge clka);
        #1;
        abort = 1'b1;
        @(posedge clka);
        #1;
        abort = 1'b0;
        @(negedge clka);
        chk(busy == 1'b0, "abort_busy", int'(busy), 0);
        chk(out_valid == 1'b0, "abort_valid", int'(out_valid), 0);
        sb.delete();
        repeat (5) @(negedge clka);
        chk(done_cnt == d0, "abort_no_done", done_cnt - d0, 0);
        chk(out_valid == 1'b0, "abort_quiet", int'(out_valid), 0);
        run_read(32'h200, 8, 1, 0, 32'h00, 8);

        // Start while busy is ignored.
        push_expect(32'h050, 10, 1);
        snap = acc_log.size();
        d0 = done_cnt;
        pulse_start(32'h050, 10, 1);
        repeat (2) @(posedge clka);
        #1;
        start = 1'b1;
        start_addr = AW'(32'h900);
        read_count = (AW + 1)'(5);
        @(posedge clka);
        #1;
        start = 1'b0;
        wait_done(d0, 200, "busy_start_done");
        chk(acc_log.size() - snap == 10, "busy_start_count", acc_log.size() - snap, 10);
        repeat (20) @(negedge clka);
        chk(done_cnt == d0 + 1, "busy_start_single", done_cnt - d0, 1);

        // Start and abort together in idle: nothing starts.
        @(posedge clka);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clka);
        chk(busy == 1'b0, "start_abort_busy", int'(busy), 0);
        repeat (3) @(negedge clka);
        chk(out_valid == 1'b0, "start_abort_valid", int'(out_valid), 0);

        // Reset mid-readout discards everything, no done.
        push_expect(32'h400, 50, 1);
        d0 = done_cnt;
        rdy_mode = 1;
        pulse_start(32'h400, 50, 1);
        repeat (6) @(posedge clka);
        #1;
        rsta = 1'b1;
        @(posedge clka);
        #1;
        rsta = 1'b0;
        rdy_mode = 0;
        @(negedge clka);
        chk(busy == 1'b0, "rst_mid_busy", int'(busy), 0);
        chk(out_valid == 1'b0, "rst_mid_valid", int'(out_valid), 0);
        chk(mem_addr == '0, "rst_mid_addr", int'(mem_addr), 0);
        chk(out_data == '0, "rst_mid_data", int'(out_data), 0);
        sb.delete();
        repeat (5) @(negedge clka);
        chk(done_cnt == d0, "rst_mid_no_done", done_cnt - d0, 0);
        run_read(32'hABC, 5, 1, 2, 32'hBC, 5);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        fork
            monitor();
            drive_ready();
            main();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
